// File: rtl/tour_sequencer.sv
// Steps a solved knight's tour through the command processor, two legs per move.
// Host commands pass straight through whenever no tour is running.
module tour_sequencer #(
    parameter int unsigned NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start_tour,
    input  logic [7:0]  i_move,
    output logic [4:0]  o_mv_indx,
    input  logic [15:0] i_cmd_uart,
    input  logic        i_cmd_rdy_uart,
    output logic        o_clr_cmd_rdy_uart,
    output logic [15:0] o_cmd,
    output logic        o_cmd_rdy,
    input  logic        i_clr_cmd_rdy,
    input  logic        i_send_resp,
    output logic [7:0]  o_resp
);

    localparam logic [4:0] LastIdx = 5'(NUM_MOVES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StVert,
        StWaitV,
        StHorz,
        StWaitH
    } state_t;

    state_t      r_state;
    logic [4:0]  r_mv_indx;

    logic        w_dx_neg;
    logic [3:0]  w_dx_mag;
    logic        w_dy_neg;
    logic [3:0]  w_dy_mag;
    logic        w_move_valid;
    logic        w_last;
    logic [15:0] w_vert_cmd;
    logic [15:0] w_horz_cmd;

    // Lowest set bit wins for multi-hot moves.
    always_comb begin
        w_dx_neg = 1'b0;
        w_dx_mag = 4'd0;
        w_dy_neg = 1'b0;
        w_dy_mag = 4'd0;
        if (i_move[0]) begin
            w_dx_neg = 1'b1; w_dx_mag = 4'd1; w_dy_mag = 4'd2;
        end else if (i_move[1]) begin
            w_dx_mag = 4'd1; w_dy_mag = 4'd2;
        end else if (i_move[2]) begin
            w_dx_neg = 1'b1; w_dx_mag = 4'd2; w_dy_mag = 4'd1;
        end else if (i_move[3]) begin
            w_dx_neg = 1'b1; w_dx_mag = 4'd2; w_dy_neg = 1'b1; w_dy_mag = 4'd1;
        end else if (i_move[4]) begin
            w_dx_neg = 1'b1; w_dx_mag = 4'd1; w_dy_neg = 1'b1; w_dy_mag = 4'd2;
        end else if (i_move[5]) begin
            w_dx_mag = 4'd1; w_dy_neg = 1'b1; w_dy_mag = 4'd2;
        end else if (i_move[6]) begin
            w_dx_mag = 4'd2; w_dy_neg = 1'b1; w_dy_mag = 4'd1;
        end else if (i_move[7]) begin
            w_dx_mag = 4'd2; w_dy_mag = 4'd1;
        end
    end

    assign w_move_valid = |i_move;
    assign w_last       = (r_mv_indx == LastIdx);
    assign w_vert_cmd   = {4'h2, (w_dy_neg ? 8'hFF : 8'h00), w_dy_mag};
    assign w_horz_cmd   = {4'h3, (w_dx_neg ? 8'h7F : 8'h3F), w_dx_mag};
    assign o_mv_indx    = r_mv_indx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_mv_indx <= 5'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start_tour) begin
                        r_mv_indx <= 5'd0;
                        r_state   <= StVert;
                    end
                end
                StVert: begin
                    // An empty move means the solver handed over a broken tour.
                    if (!w_move_valid) begin
                        r_state <= StIdle;
                    end else if (i_clr_cmd_rdy) begin
                        r_state <= StWaitV;
                    end
                end
                StWaitV: begin
                    if (i_send_resp) begin
                        r_state <= StHorz;
                    end
                end
                StHorz: begin
                    if (i_clr_cmd_rdy) begin
                        r_state <= StWaitH;
                    end
                end
                StWaitH: begin
                    if (i_send_resp) begin
                        if (w_last) begin
                            r_state <= StIdle;
                        end else begin
                            r_mv_indx <= r_mv_indx + 5'd1;
                            r_state   <= StVert;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        o_cmd              = i_cmd_uart;
        o_cmd_rdy          = 1'b0;
        o_clr_cmd_rdy_uart = 1'b0;
        o_resp             = 8'h5A;
        case (r_state)
            StVert: begin
                o_cmd     = w_vert_cmd;
                o_cmd_rdy = w_move_valid;
            end
            StWaitV: o_cmd = w_vert_cmd;
            StHorz: begin
                o_cmd     = w_horz_cmd;
                o_cmd_rdy = 1'b1;
            end
            StWaitH: begin
                o_cmd = w_horz_cmd;
                if (w_last) begin
                    o_resp = 8'hA5;
                end
            end
            default: begin
                o_cmd_rdy          = i_cmd_rdy_uart;
                o_clr_cmd_rdy_uart = i_clr_cmd_rdy;
                o_resp             = 8'hA5;
            end
        endcase
    end

endmodule
